// File: rtl/spi_pkg.sv
// Shared definitions for the mclk-domain SPI slave: parameter defaults,
// frame FSM state type and a small sizing helper.
package spi_pkg;

    localparam int SPI_WIDTH       = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_t;

    // Bit-counter width able to hold 0..w-1
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, with single-cycle
// rise/fall pulses taken from the last stage and one extra history flop.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES  = SPI_SYNC_STAGES,
    parameter logic RST_VAL = 1'b0
) (
    input  logic mclk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchronizer chain plus history stage for edge detection
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            sync_r <= {STAGES{RST_VAL}};
            prev_r <= RST_VAL;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = sync_r[STAGES-1] & ~prev_r;
    assign fall  = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave running entirely on mclk: pins are oversampled, sclk/cs
// edges drive a two-state frame FSM with sticky rx flag and error pulses.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read,
    output logic [WIDTH-1:0] data_out,
    output logic             rx_ready,
    output logic             overrun,
    output logic             frame_err,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    logic sclk_rise_s, sclk_fall_s;
    logic cs_lvl_s, cs_rise_s, cs_fall_s;
    logic mosi_lvl_s;

    logic [SYNC_STAGES-1:0] mosi_sync_r;
    spi_slv_state_t         state_r;
    logic [CW-1:0]          bit_cnt_r;
    logic [WIDTH-1:0]       rx_shift_r;
    logic [WIDTH-1:0]       tx_shift_r;
    logic [WIDTH-1:0]       tx_buf_r;
    logic [WIDTH-1:0]       data_out_r;
    logic                   rx_ready_r;
    logic                   overrun_r;
    logic                   frame_err_r;
    logic                   busy_r;
    logic                   miso_r;
    logic                   reload_r;

    logic [WIDTH-1:0]       rx_nxt_s;
    logic [WIDTH-1:0]       tx_nxt_s;
    logic                   last_bit_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .mclk  (mclk),
        .reset (reset),
        .din   (sclk),
        .level (),
        .rise  (sclk_rise_s),
        .fall  (sclk_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .mclk  (mclk),
        .reset (reset),
        .din   (cs),
        .level (cs_lvl_s),
        .rise  (cs_rise_s),
        .fall  (cs_fall_s)
    );

    // mosi needs only its level, aligned in depth with the sclk path
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_lvl_s = mosi_sync_r[SYNC_STAGES-1];
    assign rx_nxt_s   = {rx_shift_r[WIDTH-2:0], mosi_lvl_s};
    assign last_bit_s = (bit_cnt_r == LAST_BIT);

    // Next transmit shifter: reload on frame start/completion, shift on sclk fall
    always_comb begin
        tx_nxt_s = tx_shift_r;
        if (state_r == IDLE) begin
            if (cs_fall_s) begin
                tx_nxt_s = tx_buf_r;
            end else begin
                tx_nxt_s = tx_shift_r;
            end
        end else if (cs_rise_s) begin
            tx_nxt_s = tx_shift_r;
        end else if (sclk_rise_s && last_bit_s) begin
            tx_nxt_s = tx_buf_r;
        end else if (sclk_fall_s && !reload_r) begin
            tx_nxt_s = {tx_shift_r[WIDTH-2:0], 1'b0};
        end else begin
            tx_nxt_s = tx_shift_r;
        end
    end

    // Frame FSM, receive path and registered status outputs
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            bit_cnt_r   <= {CW{1'b0}};
            rx_shift_r  <= {WIDTH{1'b0}};
            tx_shift_r  <= {WIDTH{1'b0}};
            tx_buf_r    <= {WIDTH{1'b0}};
            data_out_r  <= {WIDTH{1'b0}};
            rx_ready_r  <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
            miso_r      <= 1'b0;
            reload_r    <= 1'b0;
        end else begin
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= (state_r == ACTIVE);
            tx_shift_r  <= tx_nxt_s;
            miso_r      <= cs_lvl_s ? 1'b0 : tx_nxt_s[WIDTH-1];
            if (load) begin
                tx_buf_r <= data_in;
            end
            if (read) begin
                rx_ready_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_r   <= ACTIVE;
                        bit_cnt_r <= {CW{1'b0}};
                        reload_r  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise_s) begin
                        state_r    <= IDLE;
                        bit_cnt_r  <= {CW{1'b0}};
                        rx_shift_r <= {WIDTH{1'b0}};
                        frame_err_r <= (bit_cnt_r != {CW{1'b0}});
                    end else if (sclk_rise_s) begin
                        rx_shift_r <= rx_nxt_s;
                        if (last_bit_s) begin
                            // New frame wins over a same-cycle read
                            data_out_r <= rx_nxt_s;
                            rx_ready_r <= 1'b1;
                            overrun_r  <= rx_ready_r & ~read;
                            bit_cnt_r  <= {CW{1'b0}};
                            reload_r   <= 1'b1;
                        end else begin
                            bit_cnt_r  <= bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end else if (sclk_fall_s) begin
                        reload_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign miso      = miso_r;
    assign data_out  = data_out_r;
    assign rx_ready  = rx_ready_r;
    assign overrun   = overrun_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Single-clock SPI mode-0 slave that oversamples `sclk`, `cs` and `mosi` in the `mclk` domain instead of clocking logic directly from `sclk`. It responds to the existing `spi_master`. It gives the system side a load/read byte interface with a sticky receive flag, overrun and frame-abort reporting, and back-to-back frame support. It sits beside the system logic in the top level and replaces the `sclk`-clocked slave wherever the slave must share `mclk` with the rest of the design.

## Interface
- `WIDTH`, 8: frame length in bits. Must be at least 2.
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizers. Must be at least 2.

Ports:
- `mclk`  in  1  system clock. The only clock in the block.
- `reset`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  SPI clock from the master; asynchronous to `mclk`.
- `cs`  in  1  chip select, active low; asynchronous.
- `mosi`  in  1  serial data from the master; asynchronous.
- `miso`  out  1  serial data to the master.
- `load`  in  1  1-cycle strobe: capture `data_in` into the transmit buffer.
- `data_in`  in  WIDTH  byte to transmit.
- `read`  in  1  1-cycle strobe: system has consumed `data_out`; clears `rx_ready`.
- `data_out`  out  WIDTH  last complete received frame.
- `rx_ready`  out  1  sticky flag: an unread frame is present in `data_out`.
- `overrun`  out  1  1-cycle pulse: a new frame overwrote an unread frame.
- `frame_err`  out  1  1-cycle pulse: `cs` rose in the middle of a frame.
- `busy`  out  1  high while the frame FSM is in ACTIVE.

## Operation
- Protocol is mode 0, MSB first. `mosi` is sampled on the rising edge of `sclk`. `miso` changes after the falling edge of `sclk`.
- All three inputs pass through `SYNC_STAGES` flip-flops. Rise and fall of `sclk`, and fall and rise of `cs`, are detected by comparing the last synchronized stage with one extra registered stage.
- The FSM has two states, IDLE and ACTIVE.
- IDLE to ACTIVE on detected `cs` fall:
  - `tx_shift` <= `tx_buf`.
  - `bit_cnt` <= 0.
- In ACTIVE, on detected `sclk` rise:
  - `rx_shift` <= {`rx_shift`[WIDTH-2:0], synchronized `mosi`}.
  - `bit_cnt` increments.
- When `bit_cnt` == WIDTH-1 at that rise, the frame completes:
  - `data_out` <= the new shift value; `rx_ready` <= 1.
  - `bit_cnt` <= 0; `tx_shift` <= `tx_buf`. This allows back-to-back frames without a `cs` toggle.
- In ACTIVE, on detected `sclk` fall (except directly after a completion reload): `tx_shift` shifts left by one bit.
- `miso` = `tx_shift`[WIDTH-1] while the synchronized `cs` is low, and 0 otherwise. There is no tristate; the top level gates `miso`.
- `load` in either state updates `tx_buf` only. It never disturbs a frame in flight. An unloaded `tx_buf` keeps its previous value (0 after reset).
- Overrun: if a frame completes while `rx_ready` = 1 and `read` is low, then `data_out` is overwritten, `rx_ready` stays 1, and `overrun` pulses.
- Same-cycle `read` and frame completion: the new frame wins. `rx_ready` stays 1 and there is no overrun.
- `read` with `rx_ready` = 0: no effect.
- ACTIVE to IDLE on detected `cs` rise:
  - If `bit_cnt` != 0, the partial bits are discarded and `frame_err` pulses.
  - If `bit_cnt` == 0, the return to IDLE is silent.
- `sclk` edges in IDLE are ignored.

## Timing
- Reset values (asynchronous):
  - `miso`, `data_out`, `rx_ready`, `overrun`, `frame_err` and `busy` are 0.
  - The FSM is in IDLE.
  - `tx_buf`, `tx_shift`, `rx_shift` and `bit_cnt` are 0.
  - All synchronizer stages are set to 0 for `sclk`, and to 1 for `cs` (deasserted).
- Edge-detect latency: a raw pin edge is acted on SYNC_STAGES+1 `mclk` cycles later.
- `rx_ready` and `data_out` are valid one cycle after the detected final rising edge of `sclk`. That is SYNC_STAGES+2 cycles after the raw edge.
- `miso` is updated one cycle after the detected `cs` fall or `sclk` fall.
- Input constraint: `sclk` high and low phases must each be at least SYNC_STAGES+2 `mclk` periods. The bench must honour this; the block does not check it.
- Reset asserted mid-frame: the block returns immediately to the reset values. After release, the first frame starts only on a fresh `cs` fall.
- `busy` is a registered copy of (state == ACTIVE).

## Structure
- The shared package `spi_pkg` holds:
  - `SPI_WIDTH` = 8 and `SPI_SYNC_STAGES` = 2, used as the parameter defaults.
  - The state enum `spi_slv_state_t` {IDLE, ACTIVE}.
- Sub-module `spi_sync_edge` (parameters: stage count, reset value) outputs the synchronized level plus 1-cycle `rise` and `fall` pulses.
  - One instance each for `sclk` and `cs`.
  - `mosi` uses the level output only.

## Test plan
- Load 0xA5, then the master sends 0x3C → `miso` carries 10100101; `data_out` = 0x3C; `rx_ready` = 1; `overrun` = 0.
- Two back-to-back frames 0x11 then 0x22 without `read` and with `cs` held low → `data_out` = 0x22; `overrun` pulses once; `rx_ready` = 1; the second frame's `miso` equals the `tx_buf` value at the first completion.
- Frame completes in the same cycle as a `read` strobe → `rx_ready` stays 1; no `overrun`; then a `read` alone clears `rx_ready`.
- `cs` rises after 5 bits → `frame_err` pulses; `data_out` unchanged; `rx_ready` unchanged; FSM in IDLE; the next full frame of 0x7E is received correctly.
- `load` of 0xFF mid-frame while 0x0F is transmitting → the current frame still shifts out 00001111; the next frame shifts out 0xFF.
- `reset` pulsed at bit 3 → all outputs are 0 immediately; the following frame of 0x81 is received correctly.
